// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 LCD blocks: sequencer state codes, LUT word
// layout, the clear/home command range and default 50 MHz timing.
package lcd_pkg;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t ST_IDLE  = 3'd0;
  localparam lcd_state_t ST_FETCH = 3'd1;
  localparam lcd_state_t ST_LATCH = 3'd2;
  localparam lcd_state_t ST_SETUP = 3'd3;
  localparam lcd_state_t ST_PULSE = 3'd4;
  localparam lcd_state_t ST_WAIT  = 3'd5;
  localparam lcd_state_t ST_NEXT  = 3'd6;

  localparam int RS_BIT = 8;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait
  localparam logic [7:0] CMD_LONG_FIRST = 8'h01;
  localparam logic [7:0] CMD_LONG_LAST  = 8'h03;

  localparam int DEF_SETUP_CYCLES     = 2;
  localparam int DEF_E_HIGH_CYCLES    = 12;
  localparam int DEF_WAIT_CYCLES      = 2000;
  localparam int DEF_LONG_WAIT_CYCLES = 80000;

  // Address register plus the LUT's one-cycle synchronous read
  localparam int FETCH_CYCLES = 2;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] code);
    return (rs == 1'b0) && (code >= CMD_LONG_FIRST) && (code <= CMD_LONG_LAST);
  endfunction

endpackage

// File: rtl/lcd_page_writer_if.sv
// Page-writer bus: UI request/status, text LUT read port and LCD pins.
// The writer is the master; the surrounding system is the slave.
interface lcd_page_writer_if #(
  parameter int DATA_WIDTH      = 9,
  parameter int ADDR_WIDTH      = 6,
  parameter int PAGE_ADDR_WIDTH = 5
);

  logic                       start;
  logic [PAGE_ADDR_WIDTH-1:0] page_sel;
  logic                       busy;
  logic                       done;
  logic [ADDR_WIDTH-1:0]      lut_addr;
  logic [PAGE_ADDR_WIDTH-1:0] lut_page;
  logic [DATA_WIDTH-1:0]      lut_q;
  logic                       lcd_rs;
  logic                       lcd_rw;
  logic                       lcd_e;
  logic [7:0]                 lcd_data;

  modport master (
    input  start, page_sel, lut_q,
    output busy, done, lut_addr, lut_page, lcd_rs, lcd_rw, lcd_e, lcd_data
  );

  modport slave (
    output start, page_sel, lut_q,
    input  busy, done, lut_addr, lut_page, lcd_rs, lcd_rw, lcd_e, lcd_data
  );

endinterface

// File: rtl/lcd_delay_counter.sv
// Down-counter for the sequencer's timed states: start loads N-1, and
// expired is high once the count has reached zero.
module lcd_delay_counter #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (start) begin
      count_reg <= load;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/lcd_page_writer.sv
// Reads one page of the text LUT and writes every word to an HD44780 display,
// generating RS/data setup, the E strobe and the per-command execution wait.
module lcd_page_writer
  import lcd_pkg::*;
#(
  parameter int DATA_WIDTH       = 9,
  parameter int ADDR_WIDTH       = 6,
  parameter int PAGE_ADDR_WIDTH  = 5,
  parameter int ENTRIES          = 34,
  parameter int SETUP_CYCLES     = DEF_SETUP_CYCLES,
  parameter int E_HIGH_CYCLES    = DEF_E_HIGH_CYCLES,
  parameter int WAIT_CYCLES      = DEF_WAIT_CYCLES,
  parameter int LONG_WAIT_CYCLES = DEF_LONG_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_page_writer_if.master   bus
);

  localparam int CNT_W = $clog2(LONG_WAIT_CYCLES + 1);

  localparam logic [CNT_W-1:0] FETCH_LOAD = CNT_W'(FETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(E_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_WAIT_CYCLES - 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ENTRIES - 1);

  lcd_state_t                 state_reg;
  lcd_state_t                 state_next;
  logic                       busy_reg;
  logic                       done_reg;
  logic [ADDR_WIDTH-1:0]      lut_addr_reg;
  logic [PAGE_ADDR_WIDTH-1:0] lut_page_reg;
  logic                       lcd_rs_reg;
  logic [7:0]                 lcd_data_reg;
  logic                       lcd_e_reg;
  logic                       long_wait_reg;

  logic                       cnt_start;
  logic [CNT_W-1:0]           cnt_load;
  logic                       cnt_expired;
  logic                       last_entry;
  logic [DATA_WIDTH-1:0]      word;

  assign word       = bus.lut_q;
  assign last_entry = (lut_addr_reg == LAST_ADDR);

  lcd_delay_counter #(
    .WIDTH (CNT_W)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (cnt_start),
    .load    (cnt_load),
    .expired (cnt_expired)
  );

  // Each timed state is entered with its counter freshly loaded, so it is left
  // on the edge where the count has run down to zero.
  always_comb begin
    state_next = state_reg;
    cnt_start  = 1'b0;
    cnt_load   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_FETCH;
          cnt_start  = 1'b1;
          cnt_load   = FETCH_LOAD;
        end
      end
      ST_FETCH: begin
        if (cnt_expired) begin
          state_next = ST_LATCH;
        end
      end
      ST_LATCH: begin
        state_next = ST_SETUP;
        cnt_start  = 1'b1;
        cnt_load   = SETUP_LOAD;
      end
      ST_SETUP: begin
        if (cnt_expired) begin
          state_next = ST_PULSE;
          cnt_start  = 1'b1;
          cnt_load   = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (cnt_expired) begin
          state_next = ST_WAIT;
          cnt_start  = 1'b1;
          cnt_load   = long_wait_reg ? LONG_LOAD : WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_expired) begin
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (last_entry) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_FETCH;
          cnt_start  = 1'b1;
          cnt_load   = FETCH_LOAD;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      lut_addr_reg  <= '0;
      lut_page_reg  <= '0;
      lcd_rs_reg    <= 1'b0;
      lcd_data_reg  <= 8'h00;
      lcd_e_reg     <= 1'b0;
      long_wait_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      // E comes straight from a flop, high exactly while the FSM sits in PULSE
      lcd_e_reg <= (state_next == ST_PULSE);
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            lut_page_reg <= bus.page_sel;
            lut_addr_reg <= '0;
            busy_reg     <= 1'b1;
          end
        end
        ST_LATCH: begin
          lcd_rs_reg    <= word[RS_BIT];
          lcd_data_reg  <= word[7:0];
          long_wait_reg <= is_long_cmd(word[RS_BIT], word[7:0]);
        end
        ST_NEXT: begin
          if (last_entry) begin
            lut_addr_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
          end else begin
            lut_addr_reg <= lut_addr_reg + ADDR_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.lut_addr = lut_addr_reg;
  assign bus.lut_page = lut_page_reg;
  assign bus.lcd_rs   = lcd_rs_reg;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_e    = lcd_e_reg;
  assign bus.lcd_data = lcd_data_reg;

endmodule

// File: tb/tb_lcd_page_writer.sv
// Bench for lcd_page_writer: a synchronous text_lut model plus a cycle
// schedule computed from the per-entry timing rules.
module tb_lcd_page_writer;

  localparam int ENT = 3;
  localparam int S   = 1;
  localparam int EH  = 2;
  localparam int W   = 4;
  localparam int LW  = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_page_writer_if #(.DATA_WIDTH(9), .ADDR_WIDTH(6), .PAGE_ADDR_WIDTH(5)) bus ();

  lcd_page_writer #(
    .DATA_WIDTH       (9),
    .ADDR_WIDTH       (6),
    .PAGE_ADDR_WIDTH  (5),
    .ENTRIES          (ENT),
    .SETUP_CYCLES     (S),
    .E_HIGH_CYCLES    (EH),
    .WAIT_CYCLES      (W),
    .LONG_WAIT_CYCLES (LW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [8:0] lut_mem [0:2047];
  always @(posedge clk) bus.lut_q <= lut_mem[{bus.lut_page, bus.lut_addr}];

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Runs one page and checks every cycle from edge 0 (start sampled) to the done cycle.
  // mode 0: quiet inputs; 1: lockout pokes and a restart at the done edge; 2: random junk.
  task automatic run_page(input string name, input logic [4:0] page, input bit already,
                          input int mode, input logic [4:0] next_page);
    logic [8:0] words [ENT];
    int off [ENT+1];
    int total, k, e_lo, e_hi, exp_addr;
    bit exp_e, exp_busy, exp_done;
    off[0] = 0;
    for (int i = 0; i < ENT; i++) begin
      words[i] = lut_mem[{page, 6'(i)}];
      off[i+1] = off[i] + 3 + S + EH + 1 +
                 (((words[i][8] == 1'b0) && (words[i][7:0] >= 8'h01) && (words[i][7:0] <= 8'h03)) ? LW : W);
    end
    total = off[ENT];
    if (!already) begin
      bus.page_sel = page;
      bus.start    = 1'b1;
    end
    for (int c = 0; c <= total; c++) begin
      @(negedge clk);
      k = 0;
      for (int i = 0; i < ENT; i++) if (c >= off[i]) k = i;
      e_lo     = off[k] + 3 + S;
      e_hi     = e_lo + EH;
      exp_e    = (c < total) && (c >= e_lo) && (c < e_hi);
      exp_busy = (c < total);
      exp_done = (c == total);
      exp_addr = (c < total) ? k : 0;

      n_checks++;
      if (bus.busy !== exp_busy) $display("FAIL %s busy cycle %0d: got %b required %b", name, c, bus.busy, exp_busy);
      else n_pass++;
      n_checks++;
      if (bus.done !== exp_done) $display("FAIL %s done cycle %0d: got %b required %b", name, c, bus.done, exp_done);
      else n_pass++;
      n_checks++;
      if (bus.lut_addr !== 6'(exp_addr)) $display("FAIL %s lut_addr cycle %0d: got %0d required %0d", name, c, bus.lut_addr, exp_addr);
      else n_pass++;
      n_checks++;
      if (bus.lut_page !== page) $display("FAIL %s lut_page cycle %0d: got %0d required %0d", name, c, bus.lut_page, page);
      else n_pass++;
      n_checks++;
      if (bus.lcd_e !== exp_e) $display("FAIL %s lcd_e cycle %0d: got %b required %b", name, c, bus.lcd_e, exp_e);
      else n_pass++;
      n_checks++;
      if (bus.lcd_rw !== 1'b0) $display("FAIL %s lcd_rw cycle %0d: got %b required 0", name, c, bus.lcd_rw);
      else n_pass++;
      // RS/data must be the entry's word from SETUP through the cycle after E falls
      if ((c < total) && (c >= off[k] + 3) && (c <= e_hi)) begin
        n_checks++;
        if ({bus.lcd_rs, bus.lcd_data} !== words[k])
          $display("FAIL %s rs_data entry %0d cycle %0d: got %h required %h", name, k, c, {bus.lcd_rs, bus.lcd_data}, words[k]);
        else n_pass++;
      end

      bus.start    = 1'b0;
      bus.page_sel = page;
      if (mode == 1) begin
        if (c == off[1] + 3 + S) begin
          bus.start    = 1'b1;
          bus.page_sel = 5'd5;
        end
        if (c >= total - 1) begin
          bus.start    = 1'b1;
          bus.page_sel = next_page;
        end
      end else if (mode == 2 && c < total) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.page_sel = 5'($urandom);
      end
    end
    $display("page %s: page %0d, %0d cycles to done", name, page, total);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.page_sel = 5'd7;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b required 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset done: got %b required 0", bus.done); else n_pass++;
    n_checks++; if (bus.lut_addr !== 6'd0) $display("FAIL reset lut_addr: got %0d required 0", bus.lut_addr); else n_pass++;
    n_checks++; if (bus.lut_page !== 5'd0) $display("FAIL reset lut_page: got %0d required 0", bus.lut_page); else n_pass++;
    n_checks++; if (bus.lcd_rs !== 1'b0) $display("FAIL reset lcd_rs: got %b required 0", bus.lcd_rs); else n_pass++;
    n_checks++; if (bus.lcd_rw !== 1'b0) $display("FAIL reset lcd_rw: got %b required 0", bus.lcd_rw); else n_pass++;
    n_checks++; if (bus.lcd_e !== 1'b0) $display("FAIL reset lcd_e: got %b required 0", bus.lcd_e); else n_pass++;
    n_checks++; if (bus.lcd_data !== 8'h00) $display("FAIL reset lcd_data: got %h required 00", bus.lcd_data); else n_pass++;
    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_start_ignored busy: got %b required 0", bus.busy); else n_pass++;
    n_checks++; if (bus.lut_page !== 5'd0) $display("FAIL reset_start_ignored lut_page: got %0d required 0", bus.lut_page); else n_pass++;
    $display("reset: outputs at reset values, start during reset ignored");
  endtask

  task automatic test_normal_page();
    run_page("normal", 5'd1, 1'b0, 0, 5'd0);
  endtask

  task automatic test_clear_command();
    run_page("clear", 5'd2, 1'b0, 0, 5'd0);
  endtask

  task automatic test_busy_lockout();
    run_page("lockout", 5'd1, 1'b0, 1, 5'd3);
    run_page("restart_after_done", 5'd3, 1'b1, 0, 5'd0);
  endtask

  task automatic test_reset_mid_pulse();
    bit seen;
    seen         = 1'b0;
    bus.page_sel = 5'd1;
    bus.start    = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.lcd_e === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL mid_pulse e_rise: got no E pulse in 40 cycles, required one");
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.lcd_e !== 1'b0) $display("FAIL mid_pulse async lcd_e: got %b required 0", bus.lcd_e); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_pulse async busy: got %b required 0", bus.busy); else n_pass++;
    n_checks++; if (bus.lut_page !== 5'd0) $display("FAIL mid_pulse async lut_page: got %0d required 0", bus.lut_page); else n_pass++;
    n_checks++; if (bus.lcd_data !== 8'h00) $display("FAIL mid_pulse async lcd_data: got %h required 00", bus.lcd_data); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_pulse idle busy: got %b required 0", bus.busy); else n_pass++;
    n_checks++; if (bus.lcd_e !== 1'b0) $display("FAIL mid_pulse idle lcd_e: got %b required 0", bus.lcd_e); else n_pass++;
    $display("reset mid-pulse: E dropped asynchronously, block idle after release");
    run_page("after_reset", 5'd1, 1'b0, 0, 5'd0);
  endtask

  task automatic test_random_pages();
    logic [4:0] pg;
    logic [8:0] w;
    for (int r = 0; r < 6; r++) begin
      pg = 5'($urandom_range(8, 30));
      for (int i = 0; i < ENT; i++) begin
        if ($urandom_range(0, 2) == 0) w = {1'b0, 8'($urandom_range(0, 4))};
        else w = 9'($urandom);
        lut_mem[{pg, 6'(i)}] = w;
      end
      run_page("random", pg, 1'b0, 2, 5'd0);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.page_sel = 5'd0;
    rst_n        = 1'b0;
    lut_mem[{5'd1, 6'd0}] = 9'h080;
    lut_mem[{5'd1, 6'd1}] = 9'h141;
    lut_mem[{5'd1, 6'd2}] = 9'h142;
    lut_mem[{5'd2, 6'd0}] = 9'h001;
    lut_mem[{5'd2, 6'd1}] = 9'h004;
    lut_mem[{5'd2, 6'd2}] = 9'h141;
    lut_mem[{5'd3, 6'd0}] = 9'h002;
    lut_mem[{5'd3, 6'd1}] = 9'h14F;
    lut_mem[{5'd3, 6'd2}] = 9'h0C0;

    test_reset();
    test_normal_page();
    test_clear_command();
    test_busy_lockout();
    test_reset_mid_pulse();
    test_random_pages();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
